// File: rtl/trace_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : trace_round_controller
// Purpose  : Runs one game on the 4x4 trace grid. Each round shows a
//            pseudo-random target pattern and a snitch box, clears both
//            players' traces, times the trace window and then scores each
//            player's traced boxes against the target. In two-player mode it
//            also arbitrates broom-powerup clear requests between the grids.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              system clock
//   reset_n          synchronous, active-low reset
//   start            level; starts a game from IDLE or GAME_OVER
//   two_player_mode  enables player 2 scoring and clear arbitration
//   p1/p2_traced     already_traced vectors read back from the grids
//   p1/p2_clear_req  reset_other_player_trace requests from the grids
//   displayed_trace  target pattern, bit i = box i
//   snitch_location  one-hot snitch box
//   show_en          high while the target is shown
//   reset_trace      one-cycle pulse clearing both grids
//   p1/p2_clear      one-cycle pulses to the grids' clear_my_trace
//   p1/p2_score      cumulative saturating scores
//   round            current round, 1-based (0 in IDLE)
//   state            IDLE=0 SHOW=1 TRACE=2 SCORE=3 GAME_OVER=4
//   game_over        high in GAME_OVER
// ============================================================================
module trace_round_controller #(
   parameter int unsigned SHOW_CYCLES  = 50000000,
   parameter int unsigned TRACE_CYCLES = 250000000,
   parameter int unsigned ROUNDS       = 8,
   parameter int unsigned COOLDOWN     = 100000000,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        two_player_mode,
   input  logic [15:0] p1_traced,
   input  logic [15:0] p2_traced,
   input  logic        p1_clear_req,
   input  logic        p2_clear_req,
   output logic [15:0] displayed_trace,
   output logic [15:0] snitch_location,
   output logic        show_en,
   output logic        reset_trace,
   output logic        p1_clear,
   output logic        p2_clear,
   output logic [7:0]  p1_score,
   output logic [7:0]  p2_score,
   output logic [3:0]  round,
   output logic [2:0]  state,
   output logic        game_over
);

   // One timer serves both the show and trace windows.
   localparam int unsigned c_TMAX = (SHOW_CYCLES > TRACE_CYCLES) ? SHOW_CYCLES : TRACE_CYCLES;
   localparam int          c_TW   = (c_TMAX < 2) ? 1 : $clog2(c_TMAX);
   localparam int          c_CW   = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   localparam logic [c_TW-1:0] c_SHOW_LAST  = c_TW'(SHOW_CYCLES - 1);
   localparam logic [c_TW-1:0] c_TRACE_LAST = c_TW'(TRACE_CYCLES - 1);
   localparam logic [3:0]      c_ROUNDS     = 4'(ROUNDS);
   localparam logic [c_CW-1:0] c_COOLDOWN   = c_CW'(COOLDOWN);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHOW      = 3'd1,
      S_TRACE     = 3'd2,
      S_SCORE     = 3'd3,
      S_GAME_OVER = 3'd4
   } state_t;

   state_t          state_q,   state_d;
   logic [c_TW-1:0] timer_q,   timer_d;
   logic [3:0]      round_q,   round_d;
   logic [15:0]     lfsr_q,    lfsr_d;
   logic [15:0]     disp_q,    disp_d;
   logic [15:0]     snitch_q,  snitch_d;
   logic [7:0]      p1s_q,     p1s_d;
   logic [7:0]      p2s_q,     p2s_d;
   logic            rtrace_q,  rtrace_d;
   logic            p1clr_q,   p1clr_d;
   logic            p2clr_q,   p2clr_d;
   logic            p1req_q,   p1req_d;
   logic            p2req_q,   p2req_d;
   logic [c_CW-1:0] p1cd_q,    p1cd_d;
   logic [c_CW-1:0] p2cd_q,    p2cd_d;

   logic w_load;
   logic w_arb_en;
   logic w_p1_grant;
   logic w_p2_grant;

   // Points for one round: surplus of hits over misses (floored at 0),
   // plus a flat bonus when any traced box is the snitch box.
   function automatic logic [4:0] round_points(input logic [15:0] traced,
                                               input logic [15:0] target,
                                               input logic [15:0] snitch);
      logic [4:0] hit;
      logic [4:0] miss;
      logic [4:0] pts;
      hit  = 5'd0;
      miss = 5'd0;
      for (int i = 0; i < 16; i++) begin
         if (traced[i] && target[i])  hit  = hit + 5'd1;
         if (traced[i] && !target[i]) miss = miss + 5'd1;
      end
      pts = (hit > miss) ? (hit - miss) : 5'd0;
      if ((traced & snitch) != 16'h0000) pts = pts + 5'd4;
      return pts;
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] score, input logic [4:0] pts);
      logic [8:0] sum;
      sum = {1'b0, score} + {4'b0000, pts};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // A clear request counts only on its rising edge, only while tracing in
   // two-player mode, and only once the requester's cooldown has expired.
   assign w_arb_en   = (state_q == S_TRACE) && two_player_mode;
   assign w_p1_grant = w_arb_en && p1_clear_req && !p1req_q && (p1cd_q == '0);
   assign w_p2_grant = w_arb_en && p2_clear_req && !p2req_q && (p2cd_q == '0);

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      round_d  = round_q;
      disp_d   = disp_q;
      snitch_d = snitch_q;
      p1s_d    = p1s_q;
      p2s_d    = p2s_q;
      rtrace_d = 1'b0;
      w_load   = 1'b0;
      // Fibonacci LFSR, taps 16,14,13,11, free-running in every state.
      lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      case (state_q)
         S_IDLE, S_GAME_OVER: begin
            if (start) begin
               state_d = S_SHOW;
               round_d = 4'd1;
               p1s_d   = 8'd0;
               p2s_d   = 8'd0;
               w_load  = 1'b1;
            end
         end
         S_SHOW: begin
            if (timer_q == c_SHOW_LAST) begin
               state_d = S_TRACE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_TRACE: begin
            if (timer_q == c_TRACE_LAST) begin
               state_d = S_SCORE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_SCORE: begin
            p1s_d = sat_add(p1s_q, round_points(p1_traced, disp_q, snitch_q));
            if (two_player_mode)
               p2s_d = sat_add(p2s_q, round_points(p2_traced, disp_q, snitch_q));
            if (round_q == c_ROUNDS) begin
               state_d = S_GAME_OVER;
            end else begin
               round_d = round_q + 4'd1;
               state_d = S_SHOW;
               w_load  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Entering SHOW latches a fresh target and snitch from the current LFSR
      // value and clears both grids.
      if (w_load) begin
         disp_d   = lfsr_q;
         snitch_d = 16'h0001 << lfsr_q[11:8];
         rtrace_d = 1'b1;
         timer_d  = '0;
      end

      // A grant from one player clears the other player's grid.
      p2clr_d = w_p1_grant && !rtrace_d;
      p1clr_d = w_p2_grant && !rtrace_d;
      p1req_d = p1_clear_req;
      p2req_d = p2_clear_req;

      if (w_p1_grant)         p1cd_d = c_COOLDOWN;
      else if (p1cd_q != '0)  p1cd_d = p1cd_q - 1'b1;
      else                    p1cd_d = p1cd_q;

      if (w_p2_grant)         p2cd_d = c_COOLDOWN;
      else if (p2cd_q != '0)  p2cd_d = p2cd_q - 1'b1;
      else                    p2cd_d = p2cd_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         round_q  <= 4'd0;
         lfsr_q   <= LFSR_SEED;
         disp_q   <= 16'h0000;
         snitch_q <= 16'h0000;
         p1s_q    <= 8'd0;
         p2s_q    <= 8'd0;
         rtrace_q <= 1'b0;
         p1clr_q  <= 1'b0;
         p2clr_q  <= 1'b0;
         p1req_q  <= 1'b0;
         p2req_q  <= 1'b0;
         p1cd_q   <= '0;
         p2cd_q   <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         round_q  <= round_d;
         lfsr_q   <= lfsr_d;
         disp_q   <= disp_d;
         snitch_q <= snitch_d;
         p1s_q    <= p1s_d;
         p2s_q    <= p2s_d;
         rtrace_q <= rtrace_d;
         p1clr_q  <= p1clr_d;
         p2clr_q  <= p2clr_d;
         p1req_q  <= p1req_d;
         p2req_q  <= p2req_d;
         p1cd_q   <= p1cd_d;
         p2cd_q   <= p2cd_d;
      end
   end

   assign displayed_trace = disp_q;
   assign snitch_location = snitch_q;
   assign show_en         = (state_q == S_SHOW);
   assign reset_trace     = rtrace_q;
   assign p1_clear        = p1clr_q;
   assign p2_clear        = p2clr_q;
   assign p1_score        = p1s_q;
   assign p2_score        = p2s_q;
   assign round           = round_q;
   assign state           = state_q;
   assign game_over       = (state_q == S_GAME_OVER);

endmodule
`default_nettype wire

// File: tb/tb_trace_round_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_round_controller
// Purpose  : Directed self-checking bench for trace_round_controller with
//            short windows (show 4, trace 10, 2 rounds, cooldown 3).
// Revision : 1.0  initial release
// ============================================================================
module tb_trace_round_controller;

   localparam int unsigned SHOW     = 4;
   localparam int unsigned TRACE    = 10;
   localparam int unsigned ROUNDS   = 2;
   localparam int unsigned COOLDOWN = 3;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        two_player_mode;
   logic [15:0] p1_traced;
   logic [15:0] p2_traced;
   logic        p1_clear_req;
   logic        p2_clear_req;
   logic [15:0] displayed_trace;
   logic [15:0] snitch_location;
   logic        show_en;
   logic        reset_trace;
   logic        p1_clear;
   logic        p2_clear;
   logic [7:0]  p1_score;
   logic [7:0]  p2_score;
   logic [3:0]  round;
   logic [2:0]  state;
   logic        game_over;

   trace_round_controller #(
      .SHOW_CYCLES  (SHOW),
      .TRACE_CYCLES (TRACE),
      .ROUNDS       (ROUNDS),
      .COOLDOWN     (COOLDOWN),
      .LFSR_SEED    (SEED)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .two_player_mode (two_player_mode),
      .p1_traced       (p1_traced),
      .p2_traced       (p2_traced),
      .p1_clear_req    (p1_clear_req),
      .p2_clear_req    (p2_clear_req),
      .displayed_trace (displayed_trace),
      .snitch_location (snitch_location),
      .show_en         (show_en),
      .reset_trace     (reset_trace),
      .p1_clear        (p1_clear),
      .p2_clear        (p2_clear),
      .p1_score        (p1_score),
      .p2_score        (p2_score),
      .round           (round),
      .state           (state),
      .game_over       (game_over)
   );

   always #5 clk = ~clk;

   // Reference LFSR: seed on reset, otherwise taps 16,14,13,11 shifting left.
   logic [15:0] m_lfsr;
   always @(posedge clk)
      m_lfsr <= !reset_n ? SEED : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic steps(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] snitch_of(input logic [15:0] p);
      logic [15:0] one;
      one = 16'h0001;
      return one << p[11:8];
   endfunction

   function automatic int points(input logic [15:0] tr, input logic [15:0] pat, input logic [15:0] sn);
      int h;
      int m;
      int p;
      h = $countones(tr & pat);
      m = $countones(tr & ~pat);
      p = (h > m) ? (h - m) : 0;
      if ((tr & sn) != 16'h0000) p = p + 4;
      return p;
   endfunction

   function automatic int sat(input int s, input int p);
      return (s + p > 255) ? 255 : (s + p);
   endfunction

   logic [15:0] pat1, pat2, pat3, pat4, pat5, pat6;
   int exp_p1, exp_p2;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; start = 1'b0; two_player_mode = 1'b0;
      p1_traced = 16'h0; p2_traced = 16'h0; p1_clear_req = 1'b0; p2_clear_req = 1'b0;
      steps(2);
      chk("rst_pattern", {displayed_trace, snitch_location}, 32'h0);
      chk("rst_ctl", {27'h0, show_en, reset_trace, p1_clear, p2_clear, game_over}, 32'h0);
      chk("rst_round_state", {25'h0, round, state}, 32'h0);
      chk("rst_scores", {16'h0, p1_score, p2_score}, 32'h0);

      // ---------------- game 1, round 1 (two-player) ----------------
      reset_n = 1'b1; two_player_mode = 1'b1;
      steps(2);
      pat1 = m_lfsr; start = 1'b1;
      steps(1); start = 1'b0;                                   // SHOW c1
      chk("g1r1_state_show", 32'(state), 32'd1);
      chk("g1r1_round", 32'(round), 32'd1);
      chk("g1r1_reset_trace", 32'(reset_trace), 32'd1);
      chk("g1r1_show_en", 32'(show_en), 32'd1);
      chk("g1r1_pattern", 32'(displayed_trace), 32'(pat1));
      chk("g1r1_snitch", 32'(snitch_location), 32'(snitch_of(pat1)));
      p1_clear_req = 1'b1;                                      // edge in SHOW
      steps(1);                                                 // c2
      chk("show_req_dropped", 32'(p2_clear), 32'd0);
      chk("reset_trace_one_cycle", 32'(reset_trace), 32'd0);
      steps(1); start = 1'b1;                                   // c3, start ignored
      steps(1); start = 1'b0; p1_clear_req = 1'b0;              // c4
      chk("start_ignored_state", 32'(state), 32'd1);
      chk("start_ignored_round", 32'(round), 32'd1);
      steps(1);                                                 // TRACE t1
      chk("g1r1_state_trace", 32'(state), 32'd2);
      chk("trace_show_en", 32'(show_en), 32'd0);
      chk("trace_pattern_held", 32'(displayed_trace), 32'(pat1));
      p1_clear_req = 1'b1;
      steps(1);                                                 // t2
      chk("grant_p2_clear", 32'({p1_clear, p2_clear}), 32'b01);
      p1_clear_req = 1'b0;
      steps(1);                                                 // t3
      chk("grant_one_cycle", 32'(p2_clear), 32'd0);
      p1_clear_req = 1'b1;                                      // re-rise in cooldown
      steps(1);                                                 // t4
      chk("cooldown_block_t4", 32'(p2_clear), 32'd0);
      p1_clear_req = 1'b0;
      steps(1);                                                 // t5
      chk("cooldown_block_t5", 32'(p2_clear), 32'd0);
      p1_clear_req = 1'b1;                                      // cooldown expired
      steps(1);                                                 // t6
      chk("grant_after_cooldown", 32'(p2_clear), 32'd1);
      p1_clear_req = 1'b0;
      steps(3);                                                 // t9
      p1_clear_req = 1'b1; p2_clear_req = 1'b1;
      steps(1);                                                 // t10
      chk("simultaneous_grants", 32'({p1_clear, p2_clear}), 32'b11);
      chk("g1r1_still_trace", 32'(state), 32'd2);
      p1_clear_req = 1'b0; p2_clear_req = 1'b0;
      p1_traced = 16'h0031; p2_traced = 16'hF0F0;
      steps(1);                                                 // SCORE
      chk("g1r1_state_score", 32'(state), 32'd3);
      chk("score_no_clear", 32'({p1_clear, p2_clear}), 32'b00);
      exp_p1 = sat(0, points(16'h0031, pat1, snitch_of(pat1)));
      exp_p2 = sat(0, points(16'hF0F0, pat1, snitch_of(pat1)));
      pat2 = m_lfsr;

      // ---------------- game 1, round 2 (single-player) ----------------
      steps(1);                                                 // SHOW c1
      chk("g1r2_state_show", 32'(state), 32'd1);
      chk("g1r2_round", 32'(round), 32'd2);
      chk("g1r2_reset_trace", 32'(reset_trace), 32'd1);
      chk("g1r2_pattern", 32'(displayed_trace), 32'(pat2));
      chk("g1r1_p1_score", 32'(p1_score), 32'(exp_p1));
      chk("g1r1_p2_score", 32'(p2_score), 32'(exp_p2));
      two_player_mode = 1'b0;
      steps(4);                                                 // t1
      p1_clear_req = 1'b1;
      steps(1);                                                 // t2
      chk("single_player_dropped", 32'(p2_clear), 32'd0);
      p1_clear_req = 1'b0;
      p1_traced = pat2; p2_traced = 16'hFFFF;
      steps(9);                                                 // SCORE
      chk("g1r2_state_score", 32'(state), 32'd3);
      exp_p1 = sat(exp_p1, points(pat2, pat2, snitch_of(pat2)));
      steps(1);                                                 // GAME_OVER
      chk("g1_game_over_state", 32'({game_over, state}), 32'({1'b1, 3'd4}));
      chk("g1_game_over_round", 32'(round), 32'd2);
      chk("g1_final_p1", 32'(p1_score), 32'(exp_p1));
      chk("g1_p2_frozen_single", 32'(p2_score), 32'(exp_p2));
      chk("g1_game_over_show_en", 32'(show_en), 32'd0);
      steps(2);
      chk("game_over_held", 32'({game_over, state}), 32'({1'b1, 3'd4}));
      chk("game_over_pattern_held", 32'(displayed_trace), 32'(pat2));

      // ---------------- game 2: saturation ----------------
      pat3 = m_lfsr; start = 1'b1;
      steps(1); start = 1'b0;                                   // SHOW c1
      chk("g2_round_restart", 32'(round), 32'd1);
      chk("g2_scores_cleared", 32'({p1_score, p2_score}), 32'h0);
      chk("g2_pattern", 32'(displayed_trace), 32'(pat3));
      steps(4);                                                 // t1
      force dut.p1s_q = 8'd253;
      p1_traced = snitch_of(pat3);                              // worth at least 4
      steps(10);                                                // SCORE
      chk("g2_forced_253", 32'(p1_score), 32'd253);
      pat4 = m_lfsr;
      release dut.p1s_q;
      steps(1);                                                 // r2 SHOW c1
      chk("sat_reaches_255", 32'(p1_score), 32'd255);
      p1_traced = snitch_of(pat4);
      steps(15);                                                // GAME_OVER
      chk("sat_holds_255", 32'(p1_score), 32'd255);
      chk("g2_game_over", 32'(state), 32'd4);

      // ---------------- game 3: reset mid-TRACE ----------------
      two_player_mode = 1'b1;
      pat5 = m_lfsr; start = 1'b1;
      steps(1); start = 1'b0;
      chk("g3_restart", 32'({p1_score, p2_score, 4'h0, round}), 32'h0001);
      p1_traced = pat5;
      exp_p1 = sat(0, points(pat5, pat5, snitch_of(pat5)));
      steps(15);                                                // r2 SHOW c1
      chk("g3r1_p1_score", 32'(p1_score), 32'(exp_p1));
      steps(4);                                                 // t1
      p1_clear_req = 1'b1;
      steps(1);                                                 // t2
      chk("g3_grant_before_reset", 32'(p2_clear), 32'd1);
      reset_n = 1'b0; p1_clear_req = 1'b0;
      steps(1);
      chk("midrst_pattern", {displayed_trace, snitch_location}, 32'h0);
      chk("midrst_ctl", {27'h0, show_en, reset_trace, p1_clear, p2_clear, game_over}, 32'h0);
      chk("midrst_round_state", {25'h0, round, state}, 32'h0);
      chk("midrst_scores", {16'h0, p1_score, p2_score}, 32'h0);
      reset_n = 1'b1;
      pat6 = m_lfsr; start = 1'b1;
      steps(1); start = 1'b0;
      chk("seed_reload_model", 32'(displayed_trace), 32'(pat6));
      chk("seed_reload_value", 32'(displayed_trace), 32'h0000ACE1);
      chk("seed_snitch", 32'(snitch_location), 32'h00001000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
